// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared types and constants for the bit-serial adder controller.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_bit
// Brief    : One-bit full-adder cell, the only arithmetic in the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  logic w_p;

  assign w_p = x ^ y;
  assign s   = w_p ^ z;
  assign c   = (x & y) | (z & w_p);

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Adds two WIDTH-bit operands LSB first through one full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int c_cnt_w = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_s;
  logic               w_c;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_shift;
  logic               w_busy_next;
  logic               w_done_next;

  full_adder_bit u_cell (
    .x (r_a[0]),
    .y (r_b[0]),
    .z (r_carry),
    .s (w_s),
    .c (w_c)
  );

  assign w_last      = (r_cnt == c_cnt_w'(WIDTH - 1));
  assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_start) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done come straight off flops
  always_comb begin
    w_busy_next = (w_state_next == RUN);
    w_done_next = (w_state_next == DONE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= w_sum_shift;
          r_carry <= w_c;
          r_cnt   <= r_cnt + c_cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers take the final bit directly so they are complete at the last RUN edge
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      out_busy <= w_busy_next;
      out_done <= w_done_next;
      if ((r_state == RUN) && w_last) begin
        out_sum  <= w_sum_shift;
        out_cout <= w_c;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Scoreboard bench for serial_adder_ctrl with directed and sweep vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH:0] res;
    int             cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  exp_t           sb[$];
  exp_t           mon_e;
  logic [WIDTH:0] last_res = '0;
  int             busy_run = 0;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_start (start),
    .in_a     (a),
    .in_b     (b),
    .in_cin   (cin),
    .out_busy (busy),
    .out_done (done),
    .out_sum  (sum),
    .out_cout (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and polices hold/busy behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0;
      busy_run = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("result", {cout, sum}, mon_e.res);
          check("done_cycle", cyc, mon_e.cyc);
          last_res = mon_e.res;
        end
      end else begin
        check("result_hold", {cout, sum}, last_res);
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, WIDTH);
        busy_run = 0;
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 4 * WIDTH) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // mode 0: plain, 1: operands changed mid-run, 2: stray starts in RUN and DONE
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc, input logic [WIDTH:0] res, input int mode);
    int   k;
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    e.res = res;
    e.cyc = k + WIDTH;
    sb.push_back(e);
    check("busy_rise", busy, 1);
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      a = ~ta; b = ta ^ tb_; cin = ~tc;
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
    end
    wait_drain();
  endtask

  initial begin
    int               k;
    exp_t             e;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_op(8'h3C, 8'h0F, 1'b0, 9'h04B, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 9'h100, 1);
    run_op(8'h55, 8'h11, 1'b0, 9'h066, 2);

    // Start held high across three back-to-back operations
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    e.res = 9'h101; e.cyc = k + WIDTH;           sb.push_back(e);
    e.res = 9'h080; e.cyc = k + 2 * WIDTH + 2;   sb.push_back(e);
    e.res = 9'h12D; e.cyc = k + 3 * WIDTH + 4;   sb.push_back(e);
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0;
    while (cyc < k + WIDTH + 2) @(negedge clk);
    a = 8'hC8; b = 8'h64; cin = 1'b1;
    while (cyc < k + 2 * (WIDTH + 2)) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // Reset in the middle of a run discards the operation
    @(negedge clk);
    a = 8'h77; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * WIDTH) @(negedge clk);
    run_op(8'h12, 8'h34, 1'b0, 9'h046, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc}, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
